// File: rtl/cla_shift_mult_pkg.sv
// mult_pkg: shared widths and FSM state encoding for the shift-and-add multiplier.
package mult_pkg;
    localparam int OP_W   = 8;
    localparam int PROD_W = 16;
    localparam int CNT_W  = 3;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    typedef enum logic [1:0] {IDLE = ST_IDLE, RUN = ST_RUN, DONE = ST_DONE} state_t;
endpackage

// File: rtl/cla_shift_mult_if.sv
// cla_shift_mult_if: operand/result valid-ready bundle of the multiplier.
interface cla_shift_mult_if;
    import mult_pkg::*;
    logic              in_valid, in_ready, out_valid, out_ready, busy;
    logic [OP_W-1:0]   a, b;
    logic [PROD_W-1:0] product;
    modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, product, busy);
    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, product, busy);
endinterface

// File: rtl/cla_shift_mult_adder.sv
// CLA_16bit_ripple: four 4-bit carry-lookahead groups with the group carry rippled between them.
module CLA_16bit_ripple (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [4:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < 4; i++) begin : grp
        logic [3:0] g, p;
        logic [4:0] cc;
        assign g = a[4*i +: 4] & b[4*i +: 4];
        assign p = a[4*i +: 4] ^ b[4*i +: 4];
        assign cc[0] = c[i];
        assign cc[1] = g[0] | (p[0] & cc[0]);
        assign cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cc[0]);
        assign cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cc[0]);
        assign cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                     | (p[3] & p[2] & p[1] & p[0] & cc[0]);
        assign sum[4*i +: 4] = p ^ cc[3:0];
        assign c[i+1] = cc[4];
    end
    assign cout = c[4];
endmodule

// File: rtl/cla_shift_mult.sv
// cla_shift_mult: sequential 8x8 unsigned shift-and-add multiplier using one 16-bit CLA adder.
module cla_shift_mult
    import mult_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    cla_shift_mult_if.slave bus
);
    state_t            state_q, state_d;
    logic [PROD_W-1:0] mcand_q, mcand_d, acc_q, acc_d, product_q, product_d, add_b, sum;
    logic [OP_W-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              out_valid_q, out_valid_d, busy_q, busy_d, last, cout_unused;

    assign add_b = mplier_q[0] ? mcand_q : '0;
    CLA_16bit_ripple u_add (.a(acc_q), .b(add_b), .cin(1'b0), .sum(sum), .cout(cout_unused));

    // Early exit looks at the multiplier as it will be after this cycle's shift.
    assign last = (&count_q) || (EARLY_EXIT && mplier_q[OP_W-1:1] == '0);

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;
    assign bus.busy      = busy_q;

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        count_d     = count_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                mcand_d  = {{(PROD_W-OP_W){1'b0}}, bus.a};
                mplier_d = bus.b;
                acc_d    = '0;
                count_d  = '0;
                busy_d   = 1'b1;
                state_d  = RUN;
            end
            RUN: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (last) begin
                    product_d   = sum;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: if (bus.out_ready) begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end
endmodule
